// File: rtl/mem_stage.sv
// MIPS pipeline MEM stage: holds one EXE entry, waits for the data-SRAM response,
// aligns load data and drives the WB bus plus forwarding/hazard outputs.
module mem_stage #(
  parameter int unsigned ES_TO_MS_BUS_WD = 106,
  parameter int unsigned MS_TO_WS_BUS_WD = 74
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ms_stall,
  output logic                       ms_valid,
  output logic [4:0]                 ms_rd,
  output logic [31:0]                ms_final_result,
  output logic [3:0]                 ms_rf_wen,
  output logic                       ms_reg_write
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } state_e;

  state_e                     state_q;
  logic                       ms_valid_q;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q;
  logic [31:0]                rdata_buf_q;
  logic                       rdata_buf_v_q;

  logic [2:0]  ld_op;
  logic        mem_req;
  logic [31:0] rt_value;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign {ld_op, mem_req, rt_value, gr_we, dest, alu_result, pc} = bus_q;

  logic data_ok_w;
  logic ms_ready_go;
  logic leave;
  logic latch;
  logic new_req;

  // data_ok only counts while a request is outstanding; strays elsewhere are dropped
  assign data_ok_w      = data_sram_data_ok & (state_q == WAIT);
  assign ms_ready_go    = ms_valid_q & ~ms_stall & (~mem_req | data_ok_w | rdata_buf_v_q);
  assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign leave          = ms_ready_go & ws_allowin;
  assign latch          = es_to_ms_valid & ms_allowin;
  assign new_req        = latch & es_to_ms_bus[102];

  // Load alignment
  logic [31:0] rdata_eff;
  logic [1:0]  addr;
  logic [4:0]  byte_sh;
  logic [4:0]  lwl_sh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lwl_data;
  logic [31:0] lwr_data;
  logic [3:0]  lwl_wen;
  logic [3:0]  lwr_wen;
  logic [31:0] lwl_res;
  logic [31:0] lwr_res;
  logic [31:0] final_result;
  logic [3:0]  rf_wen;

  assign rdata_eff = rdata_buf_v_q ? rdata_buf_q : data_sram_rdata;
  assign addr      = alu_result[1:0];
  assign byte_sh   = {addr, 3'b000};
  assign lwl_sh    = {2'(2'd3 - addr), 3'b000};
  assign byte_sel  = 8'(rdata_eff >> byte_sh);
  assign half_sel  = addr[1] ? rdata_eff[31:16] : rdata_eff[15:0];
  assign lwl_data  = rdata_eff << lwl_sh;
  assign lwr_data  = rdata_eff >> byte_sh;
  assign lwl_wen   = 4'(4'b1111 << (2'd3 - addr));
  assign lwr_wen   = 4'(4'b1111 >> addr);

  // Partial-word loads keep the untouched bytes of rt
  always_comb begin
    lwl_res = rt_value;
    lwr_res = rt_value;
    for (int i = 0; i < 4; i++) begin
      if (lwl_wen[i]) lwl_res[8*i +: 8] = lwl_data[8*i +: 8];
      if (lwr_wen[i]) lwr_res[8*i +: 8] = lwr_data[8*i +: 8];
    end
  end

  always_comb begin
    final_result = alu_result;
    rf_wen       = 4'b1111;
    case (ld_op)
      3'd1:    final_result = {{24{byte_sel[7]}}, byte_sel};
      3'd2:    final_result = {24'd0, byte_sel};
      3'd3:    final_result = {{16{half_sel[15]}}, half_sel};
      3'd4:    final_result = {16'd0, half_sel};
      3'd5:    final_result = rdata_eff;
      3'd6: begin
        final_result = lwl_res;
        rf_wen       = lwl_wen;
      end
      3'd7: begin
        final_result = lwr_res;
        rf_wen       = lwr_wen;
      end
      default: rf_wen = {4{gr_we}};
    endcase
  end

  assign ms_to_ws_bus    = {rf_wen, gr_we, dest, final_result, pc};
  assign ms_valid        = ms_valid_q;
  assign ms_rd           = dest;
  assign ms_final_result = final_result;
  assign ms_rf_wen       = rf_wen;
  assign ms_reg_write    = ms_valid_q & gr_we & (rf_wen != 4'd0);

  // Valid bit, response FSM and read-data buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q    <= 1'b0;
      state_q       <= IDLE;
      rdata_buf_q   <= 32'd0;
      rdata_buf_v_q <= 1'b0;
    end else begin
      if (ms_allowin) ms_valid_q <= es_to_ms_valid;
      case (state_q)
        IDLE: begin
          if (new_req) state_q <= WAIT;
        end
        WAIT: begin
          if (data_ok_w) begin
            if (leave) begin
              state_q <= new_req ? WAIT : IDLE;
            end else begin
              state_q       <= HELD;
              rdata_buf_q   <= data_sram_rdata;
              rdata_buf_v_q <= 1'b1;
            end
          end
        end
        HELD: begin
          if (leave) begin
            rdata_buf_v_q <= 1'b0;
            state_q       <= new_req ? WAIT : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Payload needs no reset: it is qualified by ms_valid_q
  always_ff @(posedge clk) begin
    if (latch) bus_q <= es_to_ms_bus;
  end

endmodule
